// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters. Round-robin accept over
// a valid/ready request channel, result returned over a valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [15:0] REQ_OPCODE,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  output logic [1:0]  RSP_VALID,
  input  logic [1:0]  RSP_READY,
  output logic [7:0]  RSP_RESULT,
  output logic        RSP_ERR,
  output logic [7:0]  ALU_OPCODE,
  output logic [7:0]  ALU_IN1,
  output logic [7:0]  ALU_IN2,
  input  logic [7:0]  ALU_OUT,
  output logic        BUSY,
  output logic        GRANT_ID
);

  generate
    if (EXEC_CYCLES < 32'd1 || EXEC_CYCLES > 32'd15) begin : g_bad_exec_cycles
      $error("alu_arbiter: EXEC_CYCLES must be within 1..15");
    end
  endgenerate

  // Opcode with bit 5 set makes the ALU tri-state its output, i.e. parks it.
  localparam logic [7:0] ALU_PARK_OP = 8'h20;
  localparam logic [3:0] CNT_LOAD    = 4'(EXEC_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        sel_s;
  logic        accept_s;
  logic        exec_done_s;
  logic        rsp_done_s;
  logic        err_s;
  logic [1:0]  req_ready_s;
  logic [3:0]  cnt_r;
  logic        last_grant_r;
  logic        grant_r;
  logic        busy_r;
  logic [7:0]  alu_opcode_r;
  logic [7:0]  alu_in1_r;
  logic [7:0]  alu_in2_r;
  logic [1:0]  rsp_valid_r;
  logic [7:0]  rsp_result_r;
  logic        rsp_err_r;

  function automatic logic op_error(input logic [7:0] opcode, input logic [7:0] b);
    logic err;
    if (opcode[5]) begin
      err = 1'b1;
    end else if (opcode[3:0] >= 4'hB) begin
      err = 1'b1;
    end else if ((opcode[3:0] == 4'h9 || opcode[3:0] == 4'hA) && b == 8'h00) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

  function automatic logic [1:0] onehot2(input logic idx);
    logic [1:0] v;
    v      = 2'b00;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: the previous owner only loses when both are pending
  always_comb begin
    sel_s = 1'b0;
    if (REQ_VALID == 2'b11) begin
      sel_s = ~last_grant_r;
    end else if (REQ_VALID[1]) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_s     = state_r;
    req_ready_s = 2'b00;
    accept_s    = 1'b0;
    exec_done_s = 1'b0;
    rsp_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID != 2'b00 && !RESET) begin
          req_ready_s = onehot2(sel_s);
          accept_s    = 1'b1;
          state_s     = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == 4'd0) begin
          exec_done_s = 1'b1;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (RSP_READY[grant_r]) begin
          rsp_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Latched operands stay on the ALU pins during EXEC, so the error check can use them
  always_comb begin
    err_s = op_error(alu_opcode_r, alu_in2_r);
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant bookkeeping and the EXEC cycle counter
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= 4'd0;
      busy_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        grant_r <= sel_s;
        cnt_r   <= CNT_LOAD;
        busy_r  <= 1'b1;
      end else if (state_r == ST_EXEC && !exec_done_s) begin
        cnt_r <= cnt_r - 4'd1;
      end else if (rsp_done_s) begin
        last_grant_r <= grant_r;
        busy_r       <= 1'b0;
      end
    end
  end

  // ALU drive: operands of the selected requester during EXEC, parked otherwise
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      alu_opcode_r <= ALU_PARK_OP;
      alu_in1_r    <= 8'h00;
      alu_in2_r    <= 8'h00;
    end else begin
      if (accept_s) begin
        alu_opcode_r <= sel_s ? REQ_OPCODE[15:8] : REQ_OPCODE[7:0];
        alu_in1_r    <= sel_s ? REQ_A[15:8]      : REQ_A[7:0];
        alu_in2_r    <= sel_s ? REQ_B[15:8]      : REQ_B[7:0];
      end else if (exec_done_s) begin
        alu_opcode_r <= ALU_PARK_OP;
        alu_in1_r    <= 8'h00;
        alu_in2_r    <= 8'h00;
      end
    end
  end

  // Response capture; result and error hold until the owner takes them
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rsp_valid_r  <= 2'b00;
      rsp_result_r <= 8'h00;
      rsp_err_r    <= 1'b0;
    end else begin
      if (exec_done_s) begin
        rsp_valid_r  <= onehot2(grant_r);
        rsp_result_r <= err_s ? 8'h00 : ALU_OUT;
        rsp_err_r    <= err_s;
      end else if (rsp_done_s) begin
        rsp_valid_r <= 2'b00;
      end
    end
  end

  assign REQ_READY  = req_ready_s;
  assign RSP_VALID  = rsp_valid_r;
  assign RSP_RESULT = rsp_result_r;
  assign RSP_ERR    = rsp_err_r;
  assign ALU_OPCODE = alu_opcode_r;
  assign ALU_IN1    = alu_in1_r;
  assign ALU_IN2    = alu_in2_r;
  assign BUSY       = busy_r;
  assign GRANT_ID   = grant_r;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters, for example the instruction datapath and a coprocessor/DMA port. It accepts one operation at a time over a valid/ready request channel and selects round-robin when both requesters are pending. It drives the ALU operand/opcode ports for a programmable number of cycles, captures the result with an error flag, and returns it over a valid/ready response channel to the requester that issued it.

Parameters:
EXEC_CYCLES, 1, ALU cycles held before sampling ALU_OUT (1..15); >1 supports a registered/retimed ALU.

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
REQ_VALID  in  2  bit i = requester i has an operation
REQ_READY  out  2  bit i = operation of requester i accepted this cycle (one-hot or zero)
REQ_OPCODE  in  16  {opcode1, opcode0}, 8 bits each, ALU opcode encoding
REQ_A  in  16  {a1, a0} first operands
REQ_B  in  16  {b1, b0} second operands
RSP_VALID  out  2  bit i = result for requester i available (one-hot or zero)
RSP_READY  in  2  bit i = requester i takes its result
RSP_RESULT  out  8  result, shared by both requesters
RSP_ERR  out  1  result invalid (see error rules)
ALU_OPCODE  out  8  to ALU OPCODE
ALU_IN1  out  8  to ALU INPUT1
ALU_IN2  out  8  to ALU INPUT2
ALU_OUT  in  8  from ALU OUTPUT
BUSY  out  1  state != IDLE
GRANT_ID  out  1  requester owning the current operation

Behaviour:
- Reset (async): state=IDLE, LAST_GRANT=1 so requester 0 wins first, cnt=0, GRANT_ID=0, RSP_VALID=0, RSP_RESULT=0, RSP_ERR=0, BUSY=0. REQ_READY is forced 0 while RESET=1.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If only one REQ_VALID bit is set, select that requester.
  - If both are set, select !LAST_GRANT.
  - REQ_READY[sel]=1 combinationally in the same cycle.
  - On the edge: latch opcode/A/B of sel, GRANT_ID<=sel, cnt<=EXEC_CYCLES-1, go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC:
  - ALU_OPCODE/IN1/IN2 = latched values, stable for the whole state.
  - If cnt!=0, decrement cnt.
  - If cnt==0: RSP_RESULT<=ALU_OUT or 0 (see error rules), RSP_ERR<=err, go to RESP.
  - REQ_READY=0.
- RESP:
  - RSP_VALID[GRANT_ID]=1; RSP_RESULT and RSP_ERR are held stable.
  - When RSP_READY[GRANT_ID]=1: LAST_GRANT<=GRANT_ID, go to IDLE.
  - RSP_READY of the other requester is ignored.
  - No new request is accepted in the same cycle. Minimum issue interval is EXEC_CYCLES+2 cycles.
- Latency: RSP_VALID rises EXEC_CYCLES+1 cycles after the accept edge.
- Outside EXEC: ALU_OPCODE=8'h20 (bit5=1, ALU tri-states its output). ALU_IN1=ALU_IN2=8'h00.
- Error rules (err=1, RSP_RESULT=8'h00):
  - opcode[5]=1: pass-through to ALU, ALU_OUT is not sampled because it is Z.
  - opcode[3:0] in 4'b1011..4'b1111: undefined operation.
  - opcode[3:0] in {1001,1010} with B==0: divide/modulo by zero.
  - Otherwise err=0 and result=ALU_OUT. Opcode bits 7:6 and 4 are ignored.
- Width: all results are 8-bit, wrap-around as produced by the ALU. The arbiter does no arithmetic.
- Request changes while not ready are ignored. Operands are sampled only on the accept edge.
- RESET mid-operation (EXEC/RESP): the operation is dropped and no response is issued. The requester must re-request.
- EXEC_CYCLES outside 1..15: compile-time error.

Test Plan:
1. EXEC_CYCLES=1. REQ0 opcode 8'h00, A=8'h0C, B=8'h05. Required: REQ_READY=2'b01 in the accept cycle; RSP_VALID=2'b01 two cycles later with RSP_RESULT=8'h11, RSP_ERR=0; ALU_OPCODE=8'h20 in IDLE.
2. After reset, both valid in the same cycle; REQ1 opcode 8'h01, A=8'h05, B=8'h07. Required: requester 0 is served first; then requester 1 gets RSP_RESULT=8'hFE, ERR=0, GRANT_ID=1.
3. Both REQ_VALID held high for 6 operations, RSP_READY tied to 2'b11. Required: grants alternate 0,1,0,1,0,1; REQ_READY is never 2'b11.
4. Opcode 8'h09, A=8'h40, B=8'h00. Required: RESULT=8'h00, ERR=1. Opcode 8'h20. Required: RESULT=8'h00, ERR=1, ALU_OPCODE=8'h20 during EXEC. Opcode 8'h0F. Required: ERR=1.
5. RSP_READY held low for 5 cycles, REQ1 valid throughout. Required: RSP_VALID, RSP_RESULT and ERR are stable; REQ_READY=0 and BUSY=1 until the handshake; REQ1 is accepted the cycle after.
6. EXEC_CYCLES=3, RESET pulsed during the 2nd EXEC cycle. Required: all outputs take reset values immediately; no RSP_VALID follows; the next request completes normally with 4-cycle latency.
